// File: rtl/settings_bank.sv
// Runtime configuration bank: menu/edit/error FSM over NUM_ITEMS bounded values.
// seg_data packs eight 5-bit display codes (0-15 hex digits, 16 blank, 17 dash, 18 S, 19 T).
module settings_bank #(
    parameter int unsigned                  NUM_ITEMS   = 4,
    parameter int unsigned                  VAL_W       = 8,
    parameter logic [NUM_ITEMS*VAL_W-1:0]   ITEM_MIN    = 32'h009C_E105,
    parameter logic [NUM_ITEMS*VAL_W-1:0]   ITEM_MAX    = 32'h0364_1F0F,
    parameter logic [NUM_ITEMS*VAL_W-1:0]   ITEM_DEF    = 32'h0200_090A,
    parameter logic [NUM_ITEMS-1:0]         ITEM_SIGNED = 4'b0110,
    parameter int unsigned                  ERR_HOLD    = 50_000_000,
    parameter logic [2:0]                   MODE_STR_ID = 3'd4,
    parameter logic [2:0]                   ERR_STR_ID  = 3'd5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_en,
    input  logic [VAL_W-1:0]             sw_val,
    input  logic                         btn_confirm,
    input  logic                         btn_esc,
    output logic [NUM_ITEMS*VAL_W-1:0]   cfg_vals,
    output logic                         cfg_update,
    output logic [2:0]                   cfg_update_idx,
    output logic                         settings_done,
    output logic                         sender_str,
    output logic [2:0]                   sender_str_id,
    input  logic                         sender_ready,
    input  logic                         sender_done,
    output logic [39:0]                  seg_data,
    output logic [7:0]                   seg_blink
);

    localparam int unsigned CntW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;

    localparam logic [4:0] CodeE     = 5'h0E;
    localparam logic [4:0] CodeBlank = 5'h10;
    localparam logic [4:0] CodeDash  = 5'h11;
    localparam logic [4:0] CodeS     = 5'h12;
    localparam logic [4:0] CodeT     = 5'h13;

    typedef enum logic [2:0] {StIdle, StWaitStr, StMenu, StEdit, StErr, StDone} state_e;

    state_e            state_q;
    logic [2:0]        idx_q;
    logic              conf_q, esc_q;
    logic [CntW-1:0]   err_cnt_q;
    logic              err_sent_q, err_seen_q;

    logic              conf_edge, esc_edge, cur_signed, in_range, neg, err_exit;
    logic [VAL_W-1:0]  cur_min, cur_max, mag;
    logic [9:0]        mag10;
    logic [3:0]        hund, tens, units;
    logic [39:0]       disp;
    logic [7:0]        blink;

    always_comb begin
        conf_edge  = btn_confirm & ~conf_q;
        esc_edge   = btn_esc & ~esc_q;
        cur_min    = '0;
        cur_max    = '0;
        cur_signed = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_min    = ITEM_MIN[i*VAL_W +: VAL_W];
                cur_max    = ITEM_MAX[i*VAL_W +: VAL_W];
                cur_signed = ITEM_SIGNED[i];
            end
        end
        if (cur_signed) begin
            in_range = ($signed(sw_val) >= $signed(cur_min)) &&
                       ($signed(sw_val) <= $signed(cur_max));
        end else begin
            in_range = (sw_val >= cur_min) && (sw_val <= cur_max);
        end

        neg   = cur_signed & sw_val[VAL_W-1];
        mag   = neg ? ((~sw_val) + VAL_W'(1)) : sw_val;
        mag10 = 10'(mag);
        hund  = 4'(mag10 / 10'd100);
        tens  = 4'((mag10 / 10'd10) % 10'd10);
        units = 4'(mag10 % 10'd10);

        // A pending error request must be answered before leaving ERR.
        err_exit = (err_cnt_q == '0) &&
                   (err_sent_q ? (err_seen_q | sender_done) : ~sender_ready);

        disp  = {8{CodeBlank}};
        blink = 8'h00;
        case (state_q)
            StMenu: disp = {CodeS, CodeE, CodeT, {5{CodeBlank}}};
            StEdit: begin
                disp  = {2'b00, idx_q, CodeDash, CodeBlank, CodeBlank,
                         (neg ? CodeDash : CodeBlank),
                         1'b0, hund, 1'b0, tens, 1'b0, units};
                blink = 8'h0F;
            end
            StErr: begin
                disp  = {CodeE, {7{CodeBlank}}};
                blink = 8'hFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            conf_q         <= 1'b0;
            esc_q          <= 1'b0;
            err_cnt_q      <= '0;
            err_sent_q     <= 1'b0;
            err_seen_q     <= 1'b0;
            cfg_vals       <= ITEM_DEF;
            cfg_update     <= 1'b0;
            cfg_update_idx <= '0;
            settings_done  <= 1'b0;
            sender_str     <= 1'b0;
            sender_str_id  <= '0;
            seg_data       <= {8{CodeBlank}};
            seg_blink      <= '0;
        end else begin
            conf_q     <= btn_confirm;
            esc_q      <= btn_esc;
            cfg_update <= 1'b0;
            sender_str <= 1'b0;
            if (!start_en) begin
                state_q       <= StIdle;
                settings_done <= 1'b0;
                seg_data      <= {8{CodeBlank}};
                seg_blink     <= '0;
            end else begin
                seg_data  <= disp;
                seg_blink <= blink;
                case (state_q)
                    StIdle: begin
                        if (sender_ready) begin
                            sender_str    <= 1'b1;
                            sender_str_id <= MODE_STR_ID;
                            state_q       <= StWaitStr;
                        end
                    end
                    StWaitStr: begin
                        if (sender_done) state_q <= StMenu;
                    end
                    StMenu: begin
                        if (esc_edge) begin
                            state_q       <= StDone;
                            settings_done <= 1'b1;
                        end else if (conf_edge && (32'(sw_val[2:0]) < NUM_ITEMS)) begin
                            idx_q   <= sw_val[2:0];
                            state_q <= StEdit;
                        end
                    end
                    StEdit: begin
                        if (esc_edge) begin
                            state_q <= StMenu;
                        end else if (conf_edge) begin
                            if (in_range) begin
                                for (int i = 0; i < NUM_ITEMS; i++) begin
                                    if (idx_q == 3'(i)) cfg_vals[i*VAL_W +: VAL_W] <= sw_val;
                                end
                                cfg_update     <= 1'b1;
                                cfg_update_idx <= idx_q;
                                state_q        <= StMenu;
                            end else begin
                                err_cnt_q  <= CntW'(ERR_HOLD - 1);
                                err_sent_q <= 1'b0;
                                err_seen_q <= 1'b0;
                                state_q    <= StErr;
                            end
                        end
                    end
                    StErr: begin
                        if (err_cnt_q != '0) err_cnt_q <= err_cnt_q - CntW'(1);
                        if (sender_done) err_seen_q <= 1'b1;
                        if (err_exit) begin
                            state_q <= StEdit;
                        end else if (!err_sent_q && sender_ready) begin
                            sender_str    <= 1'b1;
                            sender_str_id <= ERR_STR_ID;
                            err_sent_q    <= 1'b1;
                        end
                    end
                    StDone: settings_done <= 1'b1;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_settings_bank.sv
// Directed bench for settings_bank: stimulus queues expected string/update events,
// a negedge monitor pops and compares them as the DUT emits pulses.
module tb_settings_bank;

    localparam logic [31:0] MIN_V = 32'h009C_E105;
    localparam logic [31:0] MAX_V = 32'h0364_1F0F;
    localparam logic [31:0] DEF_V = 32'h0200_090A;

    localparam logic [4:0] E = 5'h0E;
    localparam logic [4:0] B = 5'h10;
    localparam logic [4:0] D = 5'h11;
    localparam logic [4:0] S = 5'h12;
    localparam logic [4:0] T = 5'h13;
    localparam logic [39:0] BLANK  = {B, B, B, B, B, B, B, B};
    localparam logic [39:0] MENU_D = {S, E, T, B, B, B, B, B};
    localparam logic [39:0] ERR_D  = {E, B, B, B, B, B, B, B};

    logic        clk, rst_n, start_en, btn_confirm, btn_esc, sender_ready, sender_done;
    logic [7:0]  sw_val;
    logic [31:0] cfg_vals;
    logic        cfg_update, settings_done, sender_str;
    logic [2:0]  cfg_update_idx, sender_str_id;
    logic [39:0] seg_data;
    logic [7:0]  seg_blink;

    settings_bank #(
        .NUM_ITEMS  (4),
        .VAL_W      (8),
        .ITEM_MIN   (MIN_V),
        .ITEM_MAX   (MAX_V),
        .ITEM_DEF   (DEF_V),
        .ITEM_SIGNED(4'b0110),
        .ERR_HOLD   (8),
        .MODE_STR_ID(3'd4),
        .ERR_STR_ID (3'd5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_en      (start_en),
        .sw_val        (sw_val),
        .btn_confirm   (btn_confirm),
        .btn_esc       (btn_esc),
        .cfg_vals      (cfg_vals),
        .cfg_update    (cfg_update),
        .cfg_update_idx(cfg_update_idx),
        .settings_done (settings_done),
        .sender_str    (sender_str),
        .sender_str_id (sender_str_id),
        .sender_ready  (sender_ready),
        .sender_done   (sender_done),
        .seg_data      (seg_data),
        .seg_blink     (seg_blink)
    );

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] val;
    } upd_t;

    upd_t       upd_q[$];
    logic [2:0] str_q[$];
    int         total = 0;
    int         bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic c, input logic e);
        btn_confirm = c;
        btn_esc     = e;
        tick();
        btn_confirm = 1'b0;
        btn_esc     = 1'b0;
        tick();
    endtask

    // Monitor: every sender_str / cfg_update pulse must match the next queued expectation.
    always @(negedge clk) begin
        logic [2:0] e_id;
        upd_t       u;
        if (rst_n) begin
            if (sender_str) begin
                if (str_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL str_unexpected: got id %0d, required no request", sender_str_id);
                end else begin
                    e_id = str_q.pop_front();
                    chk("str_id", 64'(sender_str_id), 64'(e_id));
                end
            end
            if (cfg_update) begin
                if (upd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL upd_unexpected: got idx %0d, required no update", cfg_update_idx);
                end else begin
                    u = upd_q.pop_front();
                    chk("upd_idx", 64'(cfg_update_idx), 64'(u.idx));
                    chk("upd_val", 64'((cfg_vals >> (32'(u.idx) * 8)) & 32'hFF), 64'(u.val));
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; start_en = 1'b0; sw_val = '0; btn_confirm = 1'b0; btn_esc = 1'b0;
        sender_ready = 1'b0; sender_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_cfg_vals", 64'(cfg_vals), 64'(DEF_V));
        chk("rst_done", 64'(settings_done), 64'(0));
        chk("rst_seg", 64'(seg_data), 64'(BLANK));
        chk("rst_blink", 64'(seg_blink), 64'(0));
        chk("rst_update", 64'(cfg_update), 64'(0));
        chk("rst_str", 64'(sender_str), 64'(0));

        // Mode announcement, then MENU
        str_q.push_back(3'd4);
        start_en = 1'b1; sender_ready = 1'b1;
        tick();
        sender_ready = 1'b0;
        tick();
        chk("str_pulse_width", 64'(sender_str), 64'(0));
        sender_done = 1'b1;
        tick();
        sender_done = 1'b0;
        tick();
        chk("menu_seg", 64'(seg_data), 64'(MENU_D));
        chk("menu_blink", 64'(seg_blink), 64'(0));

        // Signed write of -27 to item 1
        sw_val = 8'd1;
        press(1'b1, 1'b0);
        sw_val = 8'hE5;
        tick();
        chk("edit1_seg", 64'(seg_data), 64'({5'd1, D, B, B, D, 5'd0, 5'd2, 5'd7}));
        chk("edit1_blink", 64'(seg_blink), 64'(8'h0F));
        upd_q.push_back({3'd1, 8'hE5});
        press(1'b1, 1'b0);
        chk("cfg_after_w1", 64'(cfg_vals), 64'(32'h0200_E50A));

        // Item 2 at its signed lower bound (-100)
        sw_val = 8'd2;
        press(1'b1, 1'b0);
        sw_val = 8'h9C;
        tick();
        chk("edit2_seg", 64'(seg_data), 64'({5'd2, D, B, B, D, 5'd1, 5'd0, 5'd0}));
        upd_q.push_back({3'd2, 8'h9C});
        press(1'b1, 1'b0);

        // Item 0 out of range (16 > 15) -> ERR
        sw_val = 8'd0;
        press(1'b1, 1'b0);
        sw_val = 8'd16;
        tick();
        chk("edit0_seg", 64'(seg_data), 64'({5'd0, D, B, B, B, 5'd0, 5'd1, 5'd6}));
        str_q.push_back(3'd5);
        sender_ready = 1'b1;
        press(1'b1, 1'b0);
        sender_ready = 1'b0;
        chk("err_seg", 64'(seg_data), 64'(ERR_D));
        chk("err_blink", 64'(seg_blink), 64'(8'hFF));
        n = 0;
        while (seg_blink == 8'hFF && n < 100) begin
            sender_done = (n == 1);
            n++;
            tick();
        end
        sender_done = 1'b0;
        chk("err_hold_ge8", 64'(n >= 8 && n < 100), 64'(1));
        chk("err_back_edit", 64'(seg_blink), 64'(8'h0F));
        chk("err_cfg_kept", 64'(cfg_vals), 64'(32'h029C_E50A));

        // Still in EDIT for item 0: upper bound 15 accepted
        sw_val = 8'd15;
        tick();
        upd_q.push_back({3'd0, 8'h0F});
        press(1'b1, 1'b0);

        // Index 6 is out of the item range: stays in MENU
        sw_val = 8'd6;
        press(1'b1, 1'b0);
        tick();
        chk("bad_idx_blink", 64'(seg_blink), 64'(0));
        chk("bad_idx_seg", 64'(seg_data), 64'(MENU_D));

        // esc + confirm together: esc wins
        sw_val = 8'd1;
        press(1'b1, 1'b1);
        chk("both_done", 64'(settings_done), 64'(1));
        press(1'b1, 1'b0);
        tick();
        chk("done_hold", 64'(settings_done), 64'(1));
        chk("done_blink", 64'(seg_blink), 64'(0));

        start_en = 1'b0;
        tick();
        chk("exit_done_clr", 64'(settings_done), 64'(0));

        // Re-enter, open item 3, then abort mid-edit
        str_q.push_back(3'd4);
        start_en = 1'b1; sender_ready = 1'b1;
        tick();
        sender_ready = 1'b0; sender_done = 1'b1;
        tick();
        sender_done = 1'b0;
        sw_val = 8'd3;
        press(1'b1, 1'b0);
        sw_val = 8'd2;
        tick();
        chk("edit3_seg", 64'(seg_data), 64'({5'd3, D, B, B, B, 5'd0, 5'd0, 5'd2}));
        start_en = 1'b0;
        tick();
        chk("abort_done", 64'(settings_done), 64'(0));
        chk("abort_seg", 64'(seg_data), 64'(BLANK));
        chk("abort_blink", 64'(seg_blink), 64'(0));
        chk("abort_str", 64'(sender_str), 64'(0));
        chk("abort_cfg", 64'(cfg_vals), 64'(32'h029C_E50F));

        str_q.push_back(3'd4);
        start_en = 1'b1; sender_ready = 1'b1;
        tick();
        sender_ready = 1'b0;
        repeat (3) tick();
        chk("str_q_empty", 64'(str_q.size()), 64'(0));
        chk("upd_q_empty", 64'(upd_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
